stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch datapath. Debounces the two board keys: S5 is start/stop and S6 is lap/clear.
- Sequences the centisecond time counter through idle, run, pause and lap-hold modes. Drives the counter's enable and clear inputs and a display-freeze strobe.
- Sits between the raw key pins and the time counter / display-latch logic. Runs on the system clock.

Parameters:
- DEB_CNT, 1000000, stable-sample count (clk cycles) before a key level is accepted; 20 ms at 50 MHz.
- DEB_W, 20, width of the debounce counter; must satisfy 2^DEB_W > DEB_CNT.
- KEY_ACTIVE_LOW, 1, 1 = key pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- key_start  input  1  raw S5 pin (asynchronous, bouncy).
- key_lap  input  1  raw S6 pin (asynchronous, bouncy).
- cnt_full  input  1  time counter at maximum (99:59.99); level.
- cnt_en  output  1  time counter count enable; level.
- cnt_clr  output  1  time counter synchronous clear; one-cycle pulse.
- disp_hold  output  1  display latch freeze; 1 = display shows the captured lap value.
- state  output  2  current mode: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; cnt_en=0, cnt_clr=0, disp_hold=0.
  - Both synchronizers and debounced levels read "released"; debounce counters=0.
- Per-key debounce (identical instance for each key):
  - Two-flop synchronizer, then polarity-normalise per KEY_ACTIVE_LOW to pressed=1.
  - If sync level equals stable level, counter clears to 0.
  - Otherwise counter increments. On the cycle it equals DEB_CNT-1, stable takes the sync level and counter clears.
  - press pulse = one cycle, on the stable 0->1 transition only. Release produces no pulse. Holding a key produces exactly one pulse.
- Latency: raw edge to press pulse = 2 sync cycles + DEB_CNT cycles. Press pulse to state/output update = 1 cycle. All outputs are registered.
- Event priority in one cycle: start press > lap press > cnt_full.
- IDLE:
  - start -> RUN.
  - lap ignored.
  - cnt_full ignored.
- RUN:
  - start -> PAUSE.
  - lap -> LAP.
  - cnt_full -> PAUSE (auto-stop).
- LAP (counter keeps running, display frozen):
  - lap -> RUN (display released).
  - start -> PAUSE (display released).
  - cnt_full -> PAUSE (display released).
- PAUSE:
  - start -> RUN, only if cnt_full=0; otherwise ignored.
  - lap -> IDLE with cnt_clr pulsed high for exactly one cycle, coincident with state becoming IDLE.
- Output decode (registered from next-state):
  - cnt_en=1 in RUN and LAP, 0 otherwise.
  - disp_hold=1 only in LAP.
  - cnt_clr=1 only on the cycle entering IDLE from PAUSE; never asserted by reset.
- Simultaneous start+lap presses: only start acts; the lap press is discarded, not queued.
- cnt_full while in RUN with a start press in the same cycle -> PAUSE (single transition, no double toggle).
- Reset asserted mid-debounce or mid-state: immediate return to reset values. A key held through reset release must first pass debounce; it then generates one press pulse.

Test Plan (DEB_CNT=4, DEB_W=3, KEY_ACTIVE_LOW=1):
- Reset, then hold key_start low 10 cycles -> exactly one internal press; state 00->01 with cnt_en=1, 7 cycles after the falling edge (2 sync + 4 debounce + 1 register).
- key_start toggled every 2 cycles for 20 cycles, then left high -> no press pulse, state stays 00, cnt_en stays 0.
- From RUN: press S6 -> state=11, disp_hold=1, cnt_en=1. Press S6 again -> state=01, disp_hold=0.
- From RUN: press S5 -> state=10, cnt_en=0. Press S6 -> state=00; cnt_clr high for exactly 1 cycle; disp_hold=0.
- From LAP: drive cnt_full=1 -> next cycle state=10, cnt_en=0, disp_hold=0. Press S5 with cnt_full=1 -> state stays 10. Press S6 -> state=00 with cnt_clr pulse.
- In RUN: S5 and S6 debounced presses land on the same cycle -> state=10 (start wins), no LAP entry. Pull reset_n low mid-debounce of a key -> outputs zero immediately, state=00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces the start/stop and lap/clear keys and sequences the stopwatch counter and display.
module stopwatch_ctrl #(
  parameter int DEB_CNT        = 1000000,
  parameter int DEB_W          = 20,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_start,
  input  logic       key_lap,
  input  logic       cnt_full,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  localparam logic REL = (KEY_ACTIVE_LOW != 0);
  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CNT - 1);
  logic [1:0] raw, s1, s2, lvl, stable, press;
  logic [DEB_W-1:0] cnt [2];
  state_t cur, nxt;
  assign raw = {key_lap, key_start};
  // index 0 = start key, index 1 = lap key; pin polarity normalised so 1 means pressed
  for (genvar k = 0; k < 2; k++) begin : g_deb
    assign lvl[k] = s2[k] ^ REL;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        s1[k]     <= REL;
        s2[k]     <= REL;
        stable[k] <= 1'b0;
        press[k]  <= 1'b0;
        cnt[k]    <= '0;
      end else begin
        s1[k]    <= raw[k];
        s2[k]    <= s1[k];
        press[k] <= 1'b0;
        if (lvl[k] == stable[k]) cnt[k] <= '0;
        else if (cnt[k] == LAST) begin
          stable[k] <= lvl[k];
          press[k]  <= lvl[k];
          cnt[k]    <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
      end
  end
  // start outranks lap, which outranks cnt_full; an ignored start still swallows a coincident lap
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:  nxt = press[0] ? RUN : IDLE;
      RUN:   nxt = press[0] ? PAUSE : press[1] ? LAP : cnt_full ? PAUSE : RUN;
      LAP:   nxt = press[0] ? PAUSE : press[1] ? RUN : cnt_full ? PAUSE : LAP;
      PAUSE: nxt = press[0] ? (cnt_full ? PAUSE : RUN) : press[1] ? IDLE : PAUSE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur       <= IDLE;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      cur       <= nxt;
      cnt_en    <= (nxt == RUN) || (nxt == LAP);
      cnt_clr   <= (cur == PAUSE) && (nxt == IDLE);
      disp_hold <= (nxt == LAP);
    end
  assign state = cur;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of debounce latency, bounce rejection, mode sequencing and reset.
module tb_stopwatch_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, key_start = 1'b1, key_lap = 1'b1, cnt_full = 1'b0;
  logic cnt_en, cnt_clr, disp_hold;
  logic [1:0] state;
  int total = 0, bad = 0;
  stopwatch_ctrl #(.DEB_CNT(4), .DEB_W(3), .KEY_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .key_start(key_start), .key_lap(key_lap),
    .cnt_full(cnt_full), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold), .state(state)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [1:0] st, input logic en, input logic clr, input logic hold);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".cnt_en"}, 8'(cnt_en), 8'(en));
    chk({tag, ".cnt_clr"}, 8'(cnt_clr), 8'(clr));
    chk({tag, ".disp_hold"}, 8'(disp_hold), 8'(hold));
  endtask
  task automatic press_start();
    key_start = 1'b0;
    step(10);
    key_start = 1'b1;
    step(8);
  endtask
  task automatic press_lap();
    key_lap = 1'b0;
    step(10);
    key_lap = 1'b1;
    step(8);
  endtask
  task automatic lap_clear(input string tag);
    key_lap = 1'b0;
    step(6);
    chk({tag, ".pre_state"}, 8'(state), 8'h2);
    step(1);
    chk({tag, ".clr_on"}, 8'(cnt_clr), 8'h1);
    chk({tag, ".idle"}, 8'(state), 8'h0);
    step(1);
    chk({tag, ".clr_off"}, 8'(cnt_clr), 8'h0);
    step(2);
    key_lap = 1'b1;
    step(8);
    outs({tag, ".final"}, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    step(2);
    outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(3);
    // bouncing key: level never stable long enough
    for (int i = 0; i < 10; i++) begin
      key_start = ~key_start;
      step(2);
      chk("bounce.state", 8'(state), 8'h0);
    end
    step(10);
    outs("bounce.end", 2'b00, 1'b0, 1'b0, 1'b0);
    // latency: 2 sync + 4 debounce + 1 register
    key_start = 1'b0;
    step(6);
    chk("lat.before", 8'(state), 8'h0);
    step(1);
    outs("lat.run", 2'b01, 1'b1, 1'b0, 1'b0);
    step(3);
    key_start = 1'b1;
    step(10);
    chk("hold.one_press", 8'(state), 8'h1);
    press_lap();
    outs("lap.enter", 2'b11, 1'b1, 1'b0, 1'b1);
    press_lap();
    outs("lap.exit", 2'b01, 1'b1, 1'b0, 1'b0);
    press_start();
    outs("pause", 2'b10, 1'b0, 1'b0, 1'b0);
    lap_clear("clear1");
    press_start();
    press_lap();
    outs("lap2", 2'b11, 1'b1, 1'b0, 1'b1);
    cnt_full = 1'b1;
    step(1);
    outs("full.autostop", 2'b10, 1'b0, 1'b0, 1'b0);
    press_start();
    outs("full.start_ignored", 2'b10, 1'b0, 1'b0, 1'b0);
    cnt_full = 1'b0;
    lap_clear("clear2");
    // simultaneous start and lap presses in RUN
    press_start();
    chk("sim.run", 8'(state), 8'h1);
    key_start = 1'b0;
    key_lap = 1'b0;
    step(7);
    outs("sim.pause", 2'b10, 1'b0, 1'b0, 1'b0);
    step(3);
    key_start = 1'b1;
    key_lap = 1'b1;
    step(8);
    outs("sim.final", 2'b10, 1'b0, 1'b0, 1'b0);
    // start press coinciding with cnt_full in RUN
    press_start();
    chk("fullstart.run", 8'(state), 8'h1);
    key_start = 1'b0;
    step(6);
    cnt_full = 1'b1;
    step(1);
    outs("fullstart.pause", 2'b10, 1'b0, 1'b0, 1'b0);
    step(3);
    key_start = 1'b1;
    cnt_full = 1'b0;
    step(8);
    chk("fullstart.stay", 8'(state), 8'h2);
    // reset mid-debounce with the key held through release
    press_start();
    chk("rst.run", 8'(state), 8'h1);
    key_start = 1'b0;
    step(4);
    #2 reset_n = 1'b0;
    #1 outs("rst.async", 2'b00, 1'b0, 1'b0, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(6);
    chk("rst.held_wait", 8'(state), 8'h0);
    step(1);
    outs("rst.held_press", 2'b01, 1'b1, 1'b0, 1'b0);
    step(4);
    key_start = 1'b1;
    step(10);
    chk("rst.single", 8'(state), 8'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
